sram_bank_ctrl: RTL

Parametrised successor to the single-port SRAM bank. Wraps NUM_BANKS single-port macros behind a valid/ready request port and a pipelined read-response port. Adds per-bank chip-enable gating, byte-enable writes via an internal read-modify-write, out-of-range detection and an optional output register. Sits between on-chip memory clients and the SRAM macros.

---
 rtl/sram_bank_pkg.sv | 46 ++++
 rtl/sram_macro_model.sv | 29 ++
 rtl/sram_bank_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/sram_bank_pkg.sv
// Shared types and helpers for the banked SRAM controller: FSM states,
// latched request record, derived-width functions and the byte merge.
package sram_bank_pkg;

    localparam int unsigned REQ_AW = 32;
    localparam int unsigned REQ_DW = 256;
    localparam int unsigned REQ_NB = 32;

    typedef enum logic {
        IDLE,
        RMW_WRITE
    } state_t;

    // Sized for the widest supported configuration; narrower instances zero-extend.
    typedef struct packed {
        logic              write;
        logic [REQ_AW-1:0] addr;
        logic [REQ_DW-1:0] wdata;
        logic [REQ_NB-1:0] be;
    } req_t;

    function automatic int unsigned clog2_f(input int unsigned n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

    function automatic int unsigned bank_w_f(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic [REQ_DW-1:0] merge_bytes(
        input logic [REQ_DW-1:0] old_w,
        input logic [REQ_DW-1:0] new_w,
        input logic [REQ_NB-1:0] be,
        input int unsigned       byte_w
    );
        logic [REQ_DW-1:0] r;
        r = old_w;
        for (int unsigned i = 0; i < REQ_DW; i++) begin
            if (((i / byte_w) < REQ_NB) && be[i / byte_w]) begin
                r[i] = new_w[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sram_macro_model.sv
// Behavioural single-port SRAM macro: active-low chip and write enables,
// read-before-write, output holds when not enabled.
module sram_macro_model
    import sram_bank_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH  = 16,
    parameter  int unsigned MACRO_DEPTH = 1024,
    localparam int unsigned AW          = clog2_f(MACRO_DEPTH)
) (
    input  logic                  CLK,
    input  logic                  CEB,
    input  logic                  WEB,
    input  logic [AW-1:0]         A,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q
);

    logic [DATA_WIDTH-1:0] mem [MACRO_DEPTH];

    always_ff @(posedge CLK) begin
        if (!CEB) begin
            Q <= mem[A];
            if (!WEB) begin
                mem[A] <= D;
            end
        end
    end

endmodule

// File: rtl/sram_bank_ctrl.sv
// Banked SRAM controller: valid/ready request port, per-bank chip-enable
// gating, byte-enable writes via read-modify-write, pipelined read responses.
module sram_bank_ctrl
    import sram_bank_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH  = 16,
    parameter  int unsigned BYTE_WIDTH  = 8,
    parameter  int unsigned MACRO_DEPTH = 1024,
    parameter  int unsigned NUM_BANKS   = 6,
    parameter  int unsigned OUT_REG     = 1,
    localparam int unsigned MACRO_AW    = clog2_f(MACRO_DEPTH),
    localparam int unsigned BANK_W      = bank_w_f(NUM_BANKS),
    localparam int unsigned ADDR_WIDTH  = BANK_W + MACRO_AW,
    localparam int unsigned NUM_BYTES   = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_BYTES-1:0]  req_be,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    state_t                state, state_n;
    req_t                  req_q;
    logic                  ready_en;
    logic [BANK_W-1:0]     req_bank, rmw_bank, s1_sel;
    logic [MACRO_AW-1:0]   req_row, rmw_row, mac_addr;
    logic                  req_in_range, accept, be_full, be_none;
    logic [NUM_BANKS-1:0]  ceb_vec;
    logic                  mac_web;
    logic [DATA_WIDTH-1:0] mac_d, merged, s1_rdata;
    logic [DATA_WIDTH-1:0] macro_q [NUM_BANKS];
    logic                  rd_issue, latch_rmw;
    logic                  s1_valid, s1_err;
    logic                  unused_req;

    assign req_bank     = req_addr[ADDR_WIDTH-1:MACRO_AW];
    assign req_row      = req_addr[MACRO_AW-1:0];
    assign req_in_range = 32'(req_bank) < NUM_BANKS;
    assign req_ready    = ready_en && (state == IDLE);
    assign accept       = req_valid && req_ready;
    assign be_full      = &req_be;
    assign be_none      = ~|req_be;

    assign rmw_bank   = req_q.addr[ADDR_WIDTH-1:MACRO_AW];
    assign rmw_row    = req_q.addr[MACRO_AW-1:0];
    assign merged     = DATA_WIDTH'(merge_bytes(REQ_DW'(macro_q[rmw_bank]), req_q.wdata,
                                                req_q.be, BYTE_WIDTH));
    assign unused_req = ^req_q;

    always_comb begin
        state_n   = state;
        ceb_vec   = '1;
        mac_web   = 1'b1;
        mac_addr  = req_row;
        mac_d     = req_wdata;
        rd_issue  = 1'b0;
        latch_rmw = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!req_write) begin
                        rd_issue = 1'b1;
                        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                            if (req_in_range && (32'(req_bank) == b)) ceb_vec[b] = 1'b0;
                        end
                    end else if (req_in_range && !be_none) begin
                        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                            if (32'(req_bank) == b) ceb_vec[b] = 1'b0;
                        end
                        if (be_full) begin
                            mac_web = 1'b0;
                        end else begin
                            latch_rmw = 1'b1;
                            state_n   = RMW_WRITE;
                        end
                    end
                end
            end
            RMW_WRITE: begin
                // Macro Q now holds the old row; write back the merged word.
                for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                    if (32'(rmw_bank) == b) ceb_vec[b] = 1'b0;
                end
                mac_web  = 1'b0;
                mac_addr = rmw_row;
                mac_d    = merged;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state    <= IDLE;
            ready_en <= 1'b0;
            req_q    <= '0;
        end else begin
            state    <= state_n;
            ready_en <= 1'b1;
            if (latch_rmw) begin
                req_q <= '{write: req_write,
                           addr:  REQ_AW'(req_addr),
                           wdata: REQ_DW'(req_wdata),
                           be:    REQ_NB'(req_be)};
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        sram_macro_model #(
            .DATA_WIDTH  (DATA_WIDTH),
            .MACRO_DEPTH (MACRO_DEPTH)
        ) u_macro (
            .CLK (CLK),
            .CEB (ceb_vec[b]),
            .WEB (mac_web),
            .A   (mac_addr),
            .D   (mac_d),
            .Q   (macro_q[b])
        );
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_sel   <= '0;
        end else begin
            s1_valid <= rd_issue;
            s1_err   <= rd_issue && !req_in_range;
            if (rd_issue) s1_sel <= req_bank;
        end
    end

    assign s1_rdata = (s1_valid && !s1_err) ? macro_q[s1_sel] : '0;

    if (OUT_REG != 0) begin : g_oreg
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                rsp_valid <= 1'b0;
                rsp_err   <= 1'b0;
                rsp_rdata <= '0;
            end else begin
                rsp_valid <= s1_valid;
                rsp_err   <= s1_err;
                rsp_rdata <= s1_rdata;
            end
        end
    end else begin : g_ocomb
        assign rsp_valid = s1_valid;
        assign rsp_err   = s1_err;
        assign rsp_rdata = s1_rdata;
    end

endmodule
